// File: rtl/gate_pkg.sv
// Shared constants and FSM encoding for the gate event counter.
// Imported by the synchronizer and the counter top.
package gate_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SNAP      = 2'd1,
    WAIT_DROP = 2'd2
  } rd_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by
// a one-register edge detector producing rise/fall pulses.
module sync_edge_det
  import gate_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x_in,
  output logic x_sync,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   x_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      x_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], x_in};
      x_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign x_sync     = sync_q[SYNC_STAGES-1];
  assign rise_pulse = x_sync & ~x_d;
  assign fall_pulse = ~x_sync & x_d;

endmodule

// File: rtl/gate_event_counter.sv
// Counts synchronized rise/fall events of x_in with saturation,
// and exposes the counts through a four-phase snapshot handshake.
module gate_event_counter
  import gate_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x_in,
  input  logic               en,
  input  logic               clr,
  input  logic               rd_req,
  output logic               x_sync,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic               rd_ack,
  output logic [2*CNT_W-1:0] rd_data,
  output logic               sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] rise_cnt, rise_nxt;
  logic [CNT_W-1:0] fall_cnt, fall_nxt;
  logic             sat_nxt;
  rd_state_t        state, state_nxt;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_in      (x_in),
    .x_sync    (x_sync),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always_comb begin
    rise_nxt = rise_cnt;
    fall_nxt = fall_cnt;
    sat_nxt  = sat;
    if (clr) begin
      rise_nxt = '0;
      fall_nxt = '0;
      sat_nxt  = 1'b0;
    end else begin
      if (en && rise_pulse && rise_cnt != CNT_MAX)
        rise_nxt = rise_cnt + 1'b1;
      if (en && fall_pulse && fall_cnt != CNT_MAX)
        fall_nxt = fall_cnt + 1'b1;
      sat_nxt = sat | (rise_nxt == CNT_MAX)
                    | (fall_nxt == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
      sat      <= 1'b0;
    end else begin
      rise_cnt <= rise_nxt;
      fall_cnt <= fall_nxt;
      sat      <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (rd_req) state_nxt = SNAP;
      SNAP:      state_nxt = WAIT_DROP;
      WAIT_DROP: if (!rd_req) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Snapshot takes the pre-increment counts of the SNAP edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else if (state == SNAP) begin
      rd_ack  <= 1'b1;
      rd_data <= {rise_cnt, fall_cnt};
    end else if (state == WAIT_DROP && !rd_req) begin
      rd_ack  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gate_event_counter.sv
// Self-checking bench for gate_event_counter: cycle model plus
// directed scenarios with literal expectations.
module tb_gate_event_counter;

  localparam int S   = 2;
  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x_in = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic rd_req = 1'b0;
  logic x_sync, rise_pulse, fall_pulse, rd_ack, sat;
  logic [2*W-1:0] rd_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gate_event_counter #(
    .SYNC_STAGES(S),
    .CNT_W      (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_in      (x_in),
    .en        (en),
    .clr       (clr),
    .rd_req    (rd_req),
    .x_sync    (x_sync),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .sat       (sat)
  );

  // model: hist[0] is the newest sample of x_in
  logic [S:0]     hist = '0;
  int             m_rc = 0;
  int             m_fc = 0;
  logic           m_sat = 1'b0;
  logic           m_ack = 1'b0;
  logic [2*W-1:0] m_data = '0;
  int             m_phase = 0;

  always @(posedge clk or negedge rst_n) begin : model
    bit r, f;
    if (!rst_n) begin
      hist = '0;
      m_rc = 0;
      m_fc = 0;
      m_sat = 1'b0;
      m_ack = 1'b0;
      m_data = '0;
      m_phase = 0;
    end else begin
      r = hist[S-1] & ~hist[S];
      f = ~hist[S-1] & hist[S];
      if (m_phase == 0) begin
        if (rd_req) m_phase = 1;
      end else if (m_phase == 1) begin
        m_data = (2*W)'((m_rc << W) | m_fc);
        m_ack = 1'b1;
        m_phase = 2;
      end else if (!rd_req) begin
        m_ack = 1'b0;
        m_phase = 0;
      end
      if (clr) begin
        m_rc = 0;
        m_fc = 0;
        m_sat = 1'b0;
      end else begin
        if (en && r && m_rc < MAX) m_rc++;
        if (en && f && m_fc < MAX) m_fc++;
        if (m_rc == MAX || m_fc == MAX) m_sat = 1'b1;
      end
      hist = {hist[S-1:0], x_in};
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  int rp_hi = 0, rp_st = 0, fp_hi = 0, fp_st = 0;
  logic rp_prev = 1'b0, fp_prev = 1'b0;

  always @(negedge clk) begin
    chk("x_sync", x_sync, hist[S-1]);
    chk("rise_pulse", rise_pulse, hist[S-1] & ~hist[S]);
    chk("fall_pulse", fall_pulse, ~hist[S-1] & hist[S]);
    chk("rd_ack", rd_ack, m_ack);
    chk("rd_data", rd_data, m_data);
    chk("sat", sat, m_sat);
    if (rise_pulse) rp_hi++;
    if (rise_pulse && !rp_prev) rp_st++;
    if (fall_pulse) fp_hi++;
    if (fall_pulse && !fp_prev) fp_st++;
    rp_prev = rise_pulse;
    fp_prev = fall_pulse;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_x(int gap);
    x_in = 1'b1;
    tick(gap);
    x_in = 1'b0;
    tick(gap);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!rd_ack && n < 10) begin
      tick(1);
      n++;
    end
    chk("ack_rise", rd_ack, 1);
  endtask

  task automatic do_read(output logic [2*W-1:0] d);
    rd_req = 1'b1;
    wait_ack();
    d = rd_data;
    rd_req = 1'b0;
    tick(1);
    chk("ack_fall", rd_ack, 0);
    tick(1);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] d;
    int b_rh, b_rs, b_fh, b_fs;

    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_sat", sat, 0);
    chk("rst_ack", rd_ack, 0);

    // three pulses, 10-cycle spacing
    en = 1'b1;
    b_rh = rp_hi; b_rs = rp_st; b_fh = fp_hi; b_fs = fp_st;
    x_in = 1'b1;
    tick(1);
    chk("rise_lat1", rise_pulse, 0);
    tick(1);
    chk("rise_lat2", rise_pulse, 1);
    tick(8);
    x_in = 1'b0;
    tick(10);
    pulse_x(10);
    pulse_x(10);
    chk("rise_count", rp_st - b_rs, 3);
    chk("rise_width", rp_hi - b_rh, 3);
    chk("fall_count", fp_st - b_fs, 3);
    chk("fall_width", fp_hi - b_fh, 3);
    do_read(d);
    chk("snap_0303", d, 16'h0303);

    // saturation
    do_clr();
    for (int i = 0; i < 300; i++) pulse_x(2);
    tick(4);
    chk("sat_set", sat, 1);
    do_read(d);
    chk("snap_sat", d, 16'hffff);
    do_clr();
    chk("sat_clr", sat, 0);
    do_read(d);
    chk("snap_clr", d, 16'h0000);

    // clear beats a simultaneous increment
    for (int i = 0; i < 5; i++) pulse_x(3);
    do_read(d);
    chk("snap_0505", d, 16'h0505);
    x_in = 1'b1;
    tick(2);
    chk("pulse_at_clr", rise_pulse, 1);
    do_clr();
    do_read(d);
    chk("clr_vs_inc", d, 16'h0000);

    // counts move while snapshot is frozen
    x_in = 1'b0;
    tick(4);
    do_clr();
    pulse_x(3);
    pulse_x(3);
    rd_req = 1'b1;
    wait_ack();
    chk("frozen_a", rd_data, 16'h0202);
    for (int i = 0; i < 3; i++) pulse_x(3);
    chk("frozen_b", rd_data, 16'h0202);
    chk("ack_held", rd_ack, 1);
    rd_req = 1'b0;
    tick(1);
    chk("ack_drop", rd_ack, 0);
    // re-request right away
    do_read(d);
    chk("snap_0505b", d, 16'h0505);

    // asynchronous reset in WAIT_DROP
    do_clr();
    for (int i = 0; i < 7; i++) pulse_x(3);
    rd_req = 1'b1;
    wait_ack();
    chk("snap_0707", rd_data, 16'h0707);
    x_in = 1'b1;
    tick(1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ack", rd_ack, 0);
    chk("arst_data", rd_data, 0);
    chk("arst_sat", sat, 0);
    chk("arst_sync", x_sync, 0);
    chk("arst_rise", rise_pulse, 0);
    chk("arst_fall", fall_pulse, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    b_rs = rp_st;
    wait_ack();
    d = rd_data;
    total++;
    if (d !== 16'h0000 && d !== 16'h0100) begin
      bad++;
      $display("FAIL post_rst_snap actual=%h expected=0000|0100", d);
    end
    tick(4);
    chk("post_rst_rises", rp_st - b_rs, 1);
    rd_req = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
